// File: rtl/alu_reg_datapath_pkg.sv
// -----------------------------------------------------------------------------
// alu_reg_datapath_pkg
// Shared definitions for the ALU + register datapath:
//   - WIDTH_DEFAULT : default data width of operands, ALU result and register
//   - OC_*          : the eight 3-bit ALU operation codes
//   - reg_op_e      : the single register operation selected each cycle
//   - decode_reg_op : fixed-priority request decoder (cl > ld > inc > dec > sr > sl)
// -----------------------------------------------------------------------------
package alu_reg_datapath_pkg;

   localparam int WIDTH_DEFAULT = 4;

   // ALU operation codes
   localparam logic [2:0] OC_ADD = 3'b000;
   localparam logic [2:0] OC_SUB = 3'b001;
   localparam logic [2:0] OC_MUL = 3'b010;
   localparam logic [2:0] OC_DIV = 3'b011;
   localparam logic [2:0] OC_NOT = 3'b100;
   localparam logic [2:0] OC_XOR = 3'b101;
   localparam logic [2:0] OC_OR  = 3'b110;
   localparam logic [2:0] OC_AND = 3'b111;

   // Register operation actually performed in a cycle (reset handled separately)
   typedef enum logic [2:0] {
      REG_HOLD = 3'd0,
      REG_CLR  = 3'd1,
      REG_LD   = 3'd2,
      REG_INC  = 3'd3,
      REG_DEC  = 3'd4,
      REG_SHR  = 3'd5,
      REG_SHL  = 3'd6
   } reg_op_e;

   // Collapse the request lines into one operation; earlier checks win.
   function automatic reg_op_e decode_reg_op(
      input logic cl,
      input logic ld,
      input logic inc,
      input logic dec,
      input logic sr,
      input logic sl
   );
      reg_op_e op;
      if (cl) begin
         op = REG_CLR;
      end else if (ld) begin
         op = REG_LD;
      end else if (inc) begin
         op = REG_INC;
      end else if (dec) begin
         op = REG_DEC;
      end else if (sr) begin
         op = REG_SHR;
      end else if (sl) begin
         op = REG_SHL;
      end else begin
         op = REG_HOLD;
      end
      return op;
   endfunction

endpackage

// File: rtl/alu_reg_datapath_alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational unsigned ALU, zero latency, no clock or reset.
// Ports:
//   oc [2:0]       operation code (see OC_* in the package)
//   a  [WIDTH-1:0] operand A
//   b  [WIDTH-1:0] operand B
//   f  [WIDTH-1:0] result, truncated to WIDTH bits
// -----------------------------------------------------------------------------
module alu_core
   import alu_reg_datapath_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic [2:0]       oc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] f
);

   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quot_s;
   logic [WIDTH-1:0]   f_s;

   // Full-width product and zero-guarded quotient, computed outside the mux
   always_comb begin
      prod_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      // Division by zero is defined to give zero so f is never X.
      if (b == {WIDTH{1'b0}}) begin
         quot_s = {WIDTH{1'b0}};
      end else begin
         quot_s = a / b;
      end
   end

   // Operation select; carries, borrows and high product bits are dropped
   always_comb begin
      f_s = {WIDTH{1'b0}};
      case (oc)
         OC_ADD:  f_s = a + b;
         OC_SUB:  f_s = a - b;
         OC_MUL:  f_s = prod_s[WIDTH-1:0];
         OC_DIV:  f_s = quot_s;
         OC_NOT:  f_s = ~a;
         OC_XOR:  f_s = a ^ b;
         OC_OR:   f_s = a | b;
         OC_AND:  f_s = a & b;
         default: f_s = {WIDTH{1'b0}};
      endcase
   end

   assign f = f_s;

endmodule

// File: rtl/alu_reg_datapath.sv
// -----------------------------------------------------------------------------
// alu_reg_datapath (top)
// Combinational ALU (alu_core) alongside an independent multi-function register.
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset, clears the register only
//   oc, a, b       ALU operation code and operands
//   f              ALU result (combinational)
//   cl, ld         register clear / parallel load (data from in)
//   inc, dec       register increment / decrement, wrapping
//   sr, ir         shift right, ir enters at the MSB
//   sl, il         shift left, il enters at the LSB
//   in             parallel load data
//   out            register contents straight from the flops
// Exactly one register operation per cycle:
//   rst > cl > ld > inc > dec > sr > sl > hold.
// -----------------------------------------------------------------------------
module alu_reg_datapath
   import alu_reg_datapath_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       oc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] f,
   input  logic             cl,
   input  logic             ld,
   input  logic             inc,
   input  logic             dec,
   input  logic             sr,
   input  logic             ir,
   input  logic             sl,
   input  logic             il,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

   reg_op_e          reg_op_s;
   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] out_q;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_alu_core (
      .oc (oc),
      .a  (a),
      .b  (b),
      .f  (f)
   );

   // Pick this cycle's register operation and form the next register value
   always_comb begin
      reg_op_s = decode_reg_op(cl, ld, inc, dec, sr, sl);
      out_d    = out_q;
      case (reg_op_s)
         REG_CLR:  out_d = {WIDTH{1'b0}};
         REG_LD:   out_d = in;
         REG_INC:  out_d = out_q + ONE_C;
         REG_DEC:  out_d = out_q - ONE_C;
         REG_SHR:  out_d = {ir, out_q[WIDTH-1:1]};
         REG_SHL:  out_d = {out_q[WIDTH-2:0], il};
         REG_HOLD: out_d = out_q;
         default:  out_d = out_q;
      endcase
   end

   // Register state; reset overrides every request in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= {WIDTH{1'b0}};
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_alu_reg_datapath.sv
// -----------------------------------------------------------------------------
// tb_alu_reg_datapath
// Self-checking bench: reset check, exhaustive ALU sweep against an arithmetic
// reference, a table of register corner-case steps, a reset-vs-ALU sequence,
// and a randomized stream checked against a behavioural register model.
// -----------------------------------------------------------------------------
module tb_alu_reg_datapath;

   localparam int W = 4;
   localparam int M = 1 << W;

   logic         clk;
   logic         rst;
   logic [2:0]   oc;
   logic [W-1:0] a, b, f;
   logic         cl, ld, inc, dec, sr, ir, sl, il;
   logic [W-1:0] din;
   logic [W-1:0] dout;

   int checks;
   int failures;

   alu_reg_datapath #(.WIDTH(W)) dut (
      .clk (clk), .rst (rst), .oc (oc), .a (a), .b (b), .f (f),
      .cl (cl), .ld (ld), .inc (inc), .dec (dec), .sr (sr), .ir (ir),
      .sl (sl), .il (il), .in (din), .out (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control bundle bit order: {rst, cl, ld, inc, dec, sr, ir, sl, il}
   typedef struct {
      logic [8:0]   ctl;
      logic [W-1:0] din;
      logic [W-1:0] exp;
      string        name;
   } vec_t;

   vec_t vecs[15];

   // Reference ALU written directly from the arithmetic definition
   function automatic int alu_ref(input int op, input int x, input int y);
      case (op)
         0: return (x + y) % M;
         1: return (x - y + M) % M;
         2: return (x * y) % M;
         3: return (y == 0) ? 0 : x / y;
         4: return (M - 1) - x;
         5: return x ^ y;
         6: return x | y;
         7: return x & y;
         default: return 0;
      endcase
   endfunction

   // Reference register: one operation per edge by priority
   function automatic int reg_ref(input int m, input logic [8:0] c, input int d);
      if (c[8])      return 0;
      else if (c[7]) return 0;
      else if (c[6]) return d;
      else if (c[5]) return (m + 1) % M;
      else if (c[4]) return (m + M - 1) % M;
      else if (c[3]) return (m / 2) + (c[2] ? M / 2 : 0);
      else if (c[1]) return ((m * 2) % M) + (c[0] ? 1 : 0);
      else           return m;
   endfunction

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask

   task automatic drive_ctl(input logic [8:0] c, input logic [W-1:0] d);
      {rst, cl, ld, inc, dec, sr, ir, sl, il} = c;
      din = d;
   endtask

   // Apply controls, take one rising edge, settle past it
   task automatic step(input logic [8:0] c, input logic [W-1:0] d);
      drive_ctl(c, d);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int m;
      logic [8:0] c;
      logic [W-1:0] d;
      int ro, ra, rb;

      checks   = 0;
      failures = 0;
      oc = 3'b000; a = '0; b = '0;
      drive_ctl(9'b0, '0);

      vecs[0]  = '{9'b1_0_1_0_0_0_0_0_0, 4'b1010, 4'b0000, "rst_over_ld"};
      vecs[1]  = '{9'b0_0_1_0_0_0_0_0_0, 4'b1010, 4'b1010, "ld_after_rst"};
      vecs[2]  = '{9'b0_0_0_0_0_1_1_0_0, 4'b0000, 4'b1101, "sr_ir1"};
      vecs[3]  = '{9'b0_0_0_0_0_0_0_1_0, 4'b0000, 4'b1010, "sl_il0"};
      vecs[4]  = '{9'b0_0_1_0_0_0_0_0_0, 4'b1111, 4'b1111, "ld_1111"};
      vecs[5]  = '{9'b0_0_0_1_0_0_0_0_0, 4'b0000, 4'b0000, "inc_wrap"};
      vecs[6]  = '{9'b0_0_0_0_1_0_0_0_0, 4'b0000, 4'b1111, "dec_wrap"};
      vecs[7]  = '{9'b0_0_1_0_0_0_0_0_0, 4'b0101, 4'b0101, "ld_0101"};
      vecs[8]  = '{9'b0_1_0_1_0_0_0_0_0, 4'b0000, 4'b0000, "cl_over_inc"};
      vecs[9]  = '{9'b0_0_1_1_0_1_0_0_0, 4'b0011, 4'b0011, "ld_over_inc_sr"};
      vecs[10] = '{9'b0_1_0_0_0_0_0_0_0, 4'b0000, 4'b0000, "cl"};
      vecs[11] = '{9'b0_0_0_0_1_0_0_1_0, 4'b0000, 4'b1111, "dec_over_sl"};
      vecs[12] = '{9'b0_0_0_0_0_0_1_0_1, 4'b0000, 4'b1111, "hold_ignores_ir_il"};
      vecs[13] = '{9'b0_0_0_0_0_0_0_1_1, 4'b0110, 4'b1111, "sl_il1"};
      vecs[14] = '{9'b1_1_1_1_1_1_1_1_1, 4'b0110, 4'b0000, "rst_over_all"};

      // Reset state
      step(9'b1_0_0_0_0_0_0_0_0, '0);
      step(9'b1_0_0_0_0_0_0_0_0, '0);
      check("reset_out", dout, 4'b0000);

      // Exhaustive ALU sweep with the register idle
      drive_ctl(9'b0, '0);
      for (int o = 0; o < 8; o++) begin
         for (int x = 0; x < M; x++) begin
            for (int y = 0; y < M; y++) begin
               oc = o[2:0]; a = x[W-1:0]; b = y[W-1:0];
               #1;
               check($sformatf("alu oc=%0d a=%0d b=%0d", o, x, y), f, alu_ref(o, x, y) % M);
            end
         end
      end
      oc = 3'b000; a = 4'b1001; b = 4'b1000;
      #1 check("alu_add_carry", f, 4'b0001);
      oc = 3'b011; a = 4'b0111; b = 4'b0000;
      #1 check("alu_div_zero", f, 4'b0000);

      // Register corner-case table
      for (int i = 0; i < 15; i++) begin
         step(vecs[i].ctl, vecs[i].din);
         check(vecs[i].name, dout, vecs[i].exp);
      end

      // Reset leaves the ALU alone, and is not sticky
      step(9'b0_0_1_0_0_0_0_0_0, 4'b0110);
      oc = 3'b000; a = 4'b1001; b = 4'b1000;
      drive_ctl(9'b1_0_0_0_0_0_0_0_0, '0);
      #1 check("f_during_rst", f, 4'b0001);
      @(posedge clk); #1;
      check("rst_clears_out", dout, 4'b0000);
      check("f_after_rst_edge", f, 4'b0001);
      step(9'b0_0_0_1_0_0_0_0_0, '0);
      check("inc_after_rst", dout, 4'b0001);

      // Randomized stream against the reference models
      m = 1;
      for (int n = 0; n < 1000; n++) begin
         c[8] = ($urandom_range(0, 31) == 0);
         c[7] = ($urandom_range(0, 7) == 0);
         c[6] = ($urandom_range(0, 3) == 0);
         c[5] = ($urandom_range(0, 3) == 0);
         c[4] = ($urandom_range(0, 3) == 0);
         c[3] = ($urandom_range(0, 2) == 0);
         c[2] = $urandom_range(0, 1) == 1;
         c[1] = ($urandom_range(0, 1) == 0);
         c[0] = $urandom_range(0, 1) == 1;
         d  = W'($urandom_range(0, M - 1));
         ro = $urandom_range(0, 7);
         ra = $urandom_range(0, M - 1);
         rb = $urandom_range(0, M - 1);
         oc = ro[2:0]; a = ra[W-1:0]; b = rb[W-1:0];
         drive_ctl(c, d);
         #1;
         if (n % 50 == 0) check($sformatf("rand_alu n=%0d", n), f, alu_ref(ro, ra, rb) % M);
         m = reg_ref(m, c, int'(d));
         @(posedge clk); #1;
         check($sformatf("rand_reg n=%0d ctl=%b", n, c), dout, m[W-1:0]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
